// File: rtl/param_dff_pipe.sv
// param_dff_pipe
//   WIDTH-bit, DEPTH-stage registered delay line with one valid bit per stage.
//   The pipeline advances only when en is high. A flush invalidates every
//   stage but leaves the data words in place. A combinational tap lets you
//   read any stage, and a registered fill counter tracks how many stages
//   currently hold valid words.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset (wins over flush and en)
//   en         advance enable; the pipeline shifts only when 1
//   d          data word entering stage 0
//   d_valid    qualifier for d
//   flush      clears all valid bits; data is held and the incoming word is dropped
//   tap_sel    stage index driving tap_q / tap_valid
//   q          data of the last stage (DEPTH-1), registered
//   q_valid    valid of the last stage, registered
//   tap_q      data of stage tap_sel, or 0 when tap_sel >= DEPTH
//   tap_valid  valid of stage tap_sel, or 0 when tap_sel >= DEPTH
//   fill_count number of stages currently valid, registered

module param_dff_pipe #(
  parameter int unsigned          WIDTH     = 8,
  parameter int unsigned          DEPTH     = 4,
  parameter logic [WIDTH-1:0]     RESET_VAL = '0,
  localparam int unsigned         SEL_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned         CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  input  logic             d_valid,
  input  logic             flush,
  input  logic [SEL_W-1:0] tap_sel,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  output logic [WIDTH-1:0] tap_q,
  output logic             tap_valid,
  output logic [CNT_W-1:0] fill_count
);

  // Stage 0 is the youngest word, stage DEPTH-1 the oldest.
  logic [WIDTH-1:0] stage [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [CNT_W-1:0] fill_next;

  // Count update for an advancing edge: one word may enter and one may leave.
  // The intermediate sum can wrap when DEPTH+1 is a power of two, but the
  // modular result is exact because the true count always lies in 0..DEPTH.
  assign fill_next = fill_count + CNT_W'(d_valid) - CNT_W'(valid[DEPTH-1]);

  // Data path: every data register is reset so nothing X leaks out. A flush
  // deliberately leaves the data untouched; only the qualifiers are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage[i] <= RESET_VAL;
      end
    end else if (!flush && en) begin
      stage[0] <= d;
      for (int i = 1; i < DEPTH; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  // Valid bits and fill counter move together so the counter always equals
  // the popcount of the valid vector.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid      <= '0;
      fill_count <= '0;
    end else if (flush) begin
      valid      <= '0;
      fill_count <= '0;
    end else if (en) begin
      valid[0] <= d_valid;
      for (int i = 1; i < DEPTH; i++) begin
        valid[i] <= valid[i-1];
      end
      fill_count <= fill_next;
    end
  end

  assign q       = stage[DEPTH-1];
  assign q_valid = valid[DEPTH-1];

  // Tap mux. Selecting by comparison rather than by direct indexing keeps
  // out-of-range selects (non power-of-two DEPTH) safely at zero.
  always_comb begin
    tap_q     = '0;
    tap_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (tap_sel == SEL_W'(i)) begin
        tap_q     = stage[i];
        tap_valid = valid[i];
      end
    end
  end

endmodule

// File: tb/tb_param_dff_pipe.sv
// tb_param_dff_pipe
//   Self-checking bench for param_dff_pipe. A DEPTH=4 instance is exercised
//   with directed steps and then random traffic against a history-based
//   reference model; a DEPTH=3 instance covers mid-run reset and the
//   out-of-range tap select.
//
// Reference model: every word accepted on an advancing edge is appended to a
// history list. Stage i holds the i-th most recent accepted word (RESET_VAL if
// fewer than i+1 words exist since reset), and it is valid only if that word
// was qualified and was accepted after the most recent flush.

module tb_param_dff_pipe;

  localparam int unsigned D   = 4;
  localparam int unsigned D3  = 3;
  localparam logic [7:0]  RV  = 8'hA5;
  localparam logic [7:0]  RV3 = 8'h3C;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DEPTH=4 instance signals
  logic       rst, en, flush, d_valid;
  logic [7:0] d;
  logic [1:0] tap_sel;
  logic [7:0] q, tap_q;
  logic       q_valid, tap_valid;
  logic [2:0] fill_count;

  // DEPTH=3 instance signals
  logic       rst3, en3, flush3, d_valid3;
  logic [7:0] d3;
  logic [1:0] tap_sel3;
  logic [7:0] q3, tap_q3;
  logic       q_valid3, tap_valid3;
  logic [1:0] fill_count3;

  int assertCount = 0;
  int failCount   = 0;

  logic [7:0] histD [$];
  logic       histV [$];
  int         flushMark = 0;

  param_dff_pipe #(.WIDTH(8), .DEPTH(D), .RESET_VAL(RV)) dut (
    .clk(clk), .rst(rst), .en(en), .d(d), .d_valid(d_valid), .flush(flush),
    .tap_sel(tap_sel), .q(q), .q_valid(q_valid), .tap_q(tap_q),
    .tap_valid(tap_valid), .fill_count(fill_count)
  );

  param_dff_pipe #(.WIDTH(8), .DEPTH(D3), .RESET_VAL(RV3)) dut3 (
    .clk(clk), .rst(rst3), .en(en3), .d(d3), .d_valid(d_valid3), .flush(flush3),
    .tap_sel(tap_sel3), .q(q3), .q_valid(q_valid3), .tap_q(tap_q3),
    .tap_valid(tap_valid3), .fill_count(fill_count3)
  );

  // Single comparison point: counts the check and reports any failure.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Content of stage i as predicted by the history model.
  task automatic modelStage(input int i, output logic [7:0] md, output logic mv);
    int idx;
    idx = histD.size() - 1 - i;
    if (idx < 0) begin
      md = RV;
      mv = 1'b0;
    end else begin
      md = histD[idx];
      mv = histV[idx] && (idx >= flushMark);
    end
  endtask

  task automatic checkAgainstModel();
    logic [7:0] md;
    logic       mv;
    int         cnt;
    cnt = 0;
    for (int i = 0; i < D; i++) begin
      modelStage(i, md, mv);
      if (mv) cnt++;
    end
    modelStage(D - 1, md, mv);
    checkOutput("m_q", 32'(q), 32'(md));
    checkOutput("m_q_valid", 32'(q_valid), 32'(mv));
    modelStage(int'(tap_sel), md, mv);
    checkOutput("m_tap_q", 32'(tap_q), 32'(md));
    checkOutput("m_tap_valid", 32'(tap_valid), 32'(mv));
    checkOutput("m_fill", 32'(fill_count), 32'(cnt));
  endtask

  // Drive one cycle on the DEPTH=4 instance, update the model with what the
  // edge should have done, then compare everything against the model.
  task automatic applyStimulus(input logic r, input logic e, input logic f,
                               input logic [7:0] dd, input logic dv);
    rst = r; en = e; flush = f; d = dd; d_valid = dv;
    @(posedge clk);
    #1;
    if (r) begin
      histD.delete();
      histV.delete();
      flushMark = 0;
    end else if (f) begin
      flushMark = histD.size();
    end else if (e) begin
      histD.push_back(dd);
      histV.push_back(dv);
    end
    checkAgainstModel();
  endtask

  task automatic step3();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int         expFill [8];
    logic       expQv   [8];
    logic [7:0] bubD    [4];
    logic       bubV    [4];

    expFill = '{1, 1, 2, 2, 1, 1, 0, 0};
    expQv   = '{0, 0, 0, 1, 0, 1, 0, 0};
    bubD    = '{8'h20, 8'h21, 8'h22, 8'h23};
    bubV    = '{1'b1, 1'b0, 1'b1, 1'b0};

    rst = 1'b1; en = 1'b0; flush = 1'b0; d = '0; d_valid = 1'b0; tap_sel = '0;
    rst3 = 1'b1; en3 = 1'b0; flush3 = 1'b0; d3 = '0; d_valid3 = 1'b0; tap_sel3 = '0;

    // Reset defaults
    $display("[TB] reset defaults");
    applyStimulus(1, 0, 0, 8'h00, 0);
    applyStimulus(1, 0, 0, 8'h00, 0);
    checkOutput("rst_q", 32'(q), 32'(8'hA5));
    checkOutput("rst_q_valid", 32'(q_valid), 32'(1'b0));
    checkOutput("rst_fill", 32'(fill_count), 32'(0));
    for (int ts = 0; ts < 4; ts++) begin
      tap_sel = 2'(ts);
      #1;
      checkOutput("rst_tap_q", 32'(tap_q), 32'(8'hA5));
      checkOutput("rst_tap_valid", 32'(tap_valid), 32'(1'b0));
    end
    applyStimulus(0, 0, 0, 8'h55, 1);
    applyStimulus(0, 0, 0, 8'h56, 1);
    checkOutput("idle_q", 32'(q), 32'(8'hA5));
    checkOutput("idle_fill", 32'(fill_count), 32'(0));

    // Latency and fill
    $display("[TB] latency and fill");
    tap_sel = 2'd1;
    for (int k = 1; k <= 5; k++) begin
      applyStimulus(0, 1, 0, 8'(k), 1);
      checkOutput("lat_fill", 32'(fill_count), (k < 4) ? 32'(k) : 32'(4));
      checkOutput("lat_q_valid", 32'(q_valid), 32'(k >= 4));
      if (k >= 4) checkOutput("lat_q", 32'(q), 32'(k - 3));
      if (k == 3) begin
        checkOutput("lat_tap_q", 32'(tap_q), 32'(8'h02));
        checkOutput("lat_tap_valid", 32'(tap_valid), 32'(1'b1));
      end
    end

    // Stall
    $display("[TB] stall");
    for (int k = 0; k < 4; k++) applyStimulus(0, 1, 0, 8'(8'h10 + k), 1);
    checkOutput("stall_fill_q", 32'(q), 32'(8'h10));
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 0, 0, 8'($urandom), 1'($urandom));
      checkOutput("stall_q", 32'(q), 32'(8'h10));
      checkOutput("stall_fill", 32'(fill_count), 32'(4));
    end
    applyStimulus(0, 1, 0, 8'h14, 1);
    checkOutput("stall_resume_q", 32'(q), 32'(8'h11));

    // Bubbles
    $display("[TB] bubbles");
    applyStimulus(0, 0, 1, 8'h00, 0);
    for (int k = 0; k < 8; k++) begin
      if (k < 4) applyStimulus(0, 1, 0, bubD[k], bubV[k]);
      else       applyStimulus(0, 1, 0, 8'(8'h24 + k - 4), 0);
      checkOutput("bub_fill", 32'(fill_count), 32'(expFill[k]));
      checkOutput("bub_q_valid", 32'(q_valid), 32'(expQv[k]));
      if (k == 3) checkOutput("bub_q0", 32'(q), 32'(8'h20));
      if (k == 5) checkOutput("bub_q2", 32'(q), 32'(8'h22));
    end

    // Flush with en, then flush with rst
    $display("[TB] flush");
    for (int k = 0; k < 4; k++) applyStimulus(0, 1, 0, 8'(8'h30 + k), 1);
    tap_sel = 2'd0;
    applyStimulus(0, 1, 1, 8'h77, 1);
    checkOutput("fl_q", 32'(q), 32'(8'h30));
    checkOutput("fl_q_valid", 32'(q_valid), 32'(1'b0));
    checkOutput("fl_fill", 32'(fill_count), 32'(0));
    checkOutput("fl_tap_q", 32'(tap_q), 32'(8'h33));
    checkOutput("fl_tap_valid", 32'(tap_valid), 32'(1'b0));
    for (int k = 0; k < 2; k++) applyStimulus(0, 1, 0, 8'(8'h40 + k), 1);
    applyStimulus(1, 1, 1, 8'h77, 1);
    checkOutput("flrst_q", 32'(q), 32'(8'hA5));
    checkOutput("flrst_tap_q", 32'(tap_q), 32'(8'hA5));
    checkOutput("flrst_fill", 32'(fill_count), 32'(0));

    // Random traffic against the model
    $display("[TB] random traffic");
    for (int n = 0; n < 400; n++) begin
      tap_sel = 2'($urandom);
      applyStimulus(1'($urandom_range(0, 49) == 0),
                    1'($urandom_range(0, 3) != 0),
                    1'($urandom_range(0, 19) == 0),
                    8'($urandom), 1'($urandom));
    end

    // Odd depth: mid-run reset and out-of-range tap
    $display("[TB] depth 3");
    rst3 = 1'b0; en3 = 1'b1; d_valid3 = 1'b1; d3 = 8'h61;
    step3();
    d3 = 8'h62;
    step3();
    tap_sel3 = 2'd1;
    #1;
    checkOutput("d3_fill", 32'(fill_count3), 32'(2));
    checkOutput("d3_q_valid", 32'(q_valid3), 32'(1'b0));
    checkOutput("d3_tap_q", 32'(tap_q3), 32'(8'h61));
    checkOutput("d3_tap_valid", 32'(tap_valid3), 32'(1'b1));
    rst3 = 1'b1; d3 = 8'h63;
    step3();
    rst3 = 1'b0; en3 = 1'b0;
    checkOutput("d3_rst_q", 32'(q3), 32'(8'h3C));
    checkOutput("d3_rst_q_valid", 32'(q_valid3), 32'(1'b0));
    checkOutput("d3_rst_fill", 32'(fill_count3), 32'(0));
    for (int ts = 0; ts < 3; ts++) begin
      tap_sel3 = 2'(ts);
      #1;
      checkOutput("d3_rst_tap_q", 32'(tap_q3), 32'(8'h3C));
      checkOutput("d3_rst_tap_valid", 32'(tap_valid3), 32'(1'b0));
    end
    tap_sel3 = 2'd3;
    #1;
    checkOutput("d3_oor_tap_q", 32'(tap_q3), 32'(0));
    checkOutput("d3_oor_tap_valid", 32'(tap_valid3), 32'(1'b0));

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
